// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Multiplies finish 5 cycles after issue, divides 10; mthi/mtlo write HI/LO directly.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_hold,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        dbg_state_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Counter load values: busy spans the load value plus one cycles.
    localparam logic [3:0] MUL_LOAD = 4'd4;
    localparam logic [3:0] DIV_LOAD = 4'd9;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        is_signed_q, is_signed_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        md_op;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    assign busy        = (state_q == S_RUN);
    assign md_op       = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign md_hold     = busy | (start & md_op);
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign dbg_state_o = state_q;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
    assign mul_a   = is_signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign mul_b   = is_signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign product = mul_a * mul_b;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign a_neg = is_signed_q & a_q[31];
    assign b_neg = is_signed_q & b_q[31];
    assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
    assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d     = S_RUN;
                            is_div_d    = (op == OP_DIV) || (op == OP_DIVU);
                            is_signed_d = (op == OP_MULT) || (op == OP_DIV);
                            cnt_d       = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_LOAD : MUL_LOAD;
                            a_d         = A;
                            b_d         = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    if (!is_div_q) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vectors feed an expected-result queue that a
// negedge monitor drains whenever busy falls.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_hold;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        dbg_state;

    mul_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .md_hold     (md_hold),
        .HI          (HI),
        .LO          (LO),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;
    logic        rst_at_edge = 1'b1;
    logic        prev_busy = 1'b0;
    int          busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int lat);
        exp_q.push_back({hi, lo});
        lat_q.push_back(lat);
    endtask

    always @(posedge clk) rst_at_edge = reset;

    // Monitor: results must stay hidden while busy, then appear at the falling edge of busy.
    always @(negedge clk) begin
        logic [63:0] e;
        int          l;
        if (busy) begin
            busy_cnt++;
            check("hidden_result", {HI, LO}, {cur_hi, cur_lo});
        end else if (prev_busy && !rst_at_edge) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result_hilo", {HI, LO}, e);
                check("busy_cycles", 64'(busy_cnt), 64'(l));
                cur_hi = e[63:32];
                cur_lo = e[31:0];
            end
        end
        if (!busy) busy_cnt = 0;
        prev_busy = busy;
    end

    // ---------------- driver ----------------
    // Drives one issue cycle, checks md_hold before the edge, then scrambles operands.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_hold);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        check("md_hold_issue", 64'(md_hold), 64'(exp_hold));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[1] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[2] = '{3'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4] = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[7] = '{3'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        check("reset_md_hold", 64'(md_hold), 64'd0);
        reset = 1'b0;

        // Signed mult with the md_hold window swept cycle by cycle.
        push(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
        issue(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("md_hold_window", 64'(md_hold), (k < 6) ? 64'd1 : 64'd0);
        end

        foreach (vecs[i]) begin
            push(vecs[i].hi, vecs[i].lo, vecs[i].lat);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            wait_idle();
        end

        // mthi then mtlo on consecutive cycles.
        issue(3'd5, 32'h12345678, 32'h0, 1'b0);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_hi", 64'(HI), 64'h12345678);
        issue(3'd6, 32'h00000009, 32'h0, 1'b0);
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mtlo_hilo", {HI, LO}, {32'h12345678, 32'h00000009});
        cur_hi = 32'h12345678;
        cur_lo = 32'h00000009;

        // Ops 0 and 7 are no-ops.
        issue(3'd0, 32'hAAAAAAAA, 32'h1, 1'b0);
        issue(3'd7, 32'h55555555, 32'h1, 1'b0);
        @(negedge clk);
        check("noop_busy", 64'(busy), 64'd0);
        check("noop_hilo", {HI, LO}, {32'h12345678, 32'h00000009});

        // Back-to-back: next op issued in the cycle right after busy falls.
        push(32'h0, 32'd12, 5);
        issue(3'd1, 32'd3, 32'd4, 1'b1);
        wait_idle();
        push(32'h2, 32'hE, 10);
        issue(3'd4, 32'd100, 32'd7, 1'b1);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_idle();

        // mult and mthi issued while a div runs are ignored.
        push(32'd2, 32'd6, 10);
        issue(3'd3, 32'd20, 32'd3, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(3'd1, 32'd7, 32'd7, 1'b1);
        issue(3'd5, 32'hDEADBEEF, 32'd0, 1'b1);
        wait_idle();

        // Reset aborts an in-flight div; a mult issued at cycle 3 is ignored.
        push(32'd0, 32'd0, 10);
        issue(3'd3, 32'd20, 32'd3, 1'b1);
        repeat (1) begin
            @(posedge clk);
            #1;
        end
        issue(3'd1, 32'd9, 32'd9, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        repeat (15) @(negedge clk);
        check("abort_no_write", {HI, LO}, 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // Reset wins over a simultaneous start.
        issue(3'd5, 32'h00000055, 32'd0, 1'b0);
        check("pre_prio_hi", 64'(HI), 64'h55);
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd1;
        A     = 32'd5;
        B     = 32'd5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        check("prio_busy", 64'(busy), 64'd0);
        check("prio_hilo", {HI, LO}, 64'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        @(negedge clk);
        check("prio_still_idle", 64'(busy), 64'd0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
